// File: rtl/data_memory_ram_init.sv
// rtl/data_memory_ram_init.sv - single-port write-first data RAM with self-init fill engine
// The fill engine owns the array after reset or clr; core accesses are honoured only once ready is high.
module data_memory_ram_init #(
   parameter int                DATA_W    = 4,
   parameter int                ADDR_W    = 4,
   parameter logic [DATA_W-1:0] INIT_SEED = {DATA_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   input  logic              clr,
   output logic [DATA_W-1:0] q,
   output logic              ready,
   output logic              wr_drop
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_INIT,
      S_READY
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic [DATA_W-1:0]   r_q;
   logic                r_ready;
   logic                r_drop;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic [DATA_W-1:0]   w_q_nxt;
   logic                w_drop_nxt;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic [DATA_W-1:0]   w_pattern;

   // Descending fill pattern, wrapping modulo 2**DATA_W.
   assign w_pattern = INIT_SEED - DATA_W'(r_cnt);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_q_nxt     = '0;
      w_drop_nxt  = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = address;
      w_mem_wdata = data;
      case (r_state)
         S_INIT: begin
            w_drop_nxt = wren;
            if (clr) begin
               w_cnt_nxt = '0;
            end else begin
               w_mem_we    = 1'b1;
               w_mem_addr  = r_cnt;
               w_mem_wdata = w_pattern;
               // Counter is exactly ADDR_W bits, so all-ones marks the last word.
               if (&r_cnt) begin
                  w_state_nxt = S_READY;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + ADDR_W'(1);
               end
            end
         end
         S_READY: begin
            if (clr) begin
               w_state_nxt = S_INIT;
               w_cnt_nxt   = '0;
               w_drop_nxt  = wren;
            end else if (wren) begin
               w_mem_we = 1'b1;
               w_q_nxt  = data;
            end else begin
               w_q_nxt = r_mem[address];
            end
         end
         default: begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_q     <= '0;
         r_ready <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q     <= w_q_nxt;
         r_ready <= (w_state_nxt == S_READY);
         r_drop  <= w_drop_nxt;
      end
   end

   // Array is deliberately unreset; the fill engine overwrites every word.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   assign q       = r_q;
   assign ready   = r_ready;
   assign wr_drop = r_drop;

endmodule

// File: tb/tb_data_memory_ram_init.sv
// tb/tb_data_memory_ram_init.sv - directed scoreboard bench for data_memory_ram_init
module tb_data_memory_ram_init;

   logic       clock;
   logic       reset_n;
   logic [3:0] address;
   logic [3:0] data;
   logic       wren;
   logic       clr;
   logic [3:0] q;
   logic       ready;
   logic       wr_drop;

   logic       rst2_n;
   logic [5:0] c2_address;
   logic [7:0] c2_data;
   logic       c2_wren;
   logic       c2_clr;
   logic [7:0] c2_q;
   logic       c2_ready;
   logic       c2_drop;

   int         n_vec;
   int         n_fail;
   logic [7:0] exp_q [$];
   string      tag_q [$];

   data_memory_ram_init #(.DATA_W(4), .ADDR_W(4)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .address (address),
      .data    (data),
      .wren    (wren),
      .clr     (clr),
      .q       (q),
      .ready   (ready),
      .wr_drop (wr_drop)
   );

   data_memory_ram_init #(.DATA_W(8), .ADDR_W(6)) u_dut2 (
      .clock   (clock),
      .reset_n (rst2_n),
      .address (c2_address),
      .data    (c2_data),
      .wren    (c2_wren),
      .clr     (c2_clr),
      .q       (c2_q),
      .ready   (c2_ready),
      .wr_drop (c2_drop)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic access(input string tag, input logic we, input logic [3:0] a,
                         input logic [3:0] d, input logic [3:0] exp);
      address = a;
      data    = d;
      wren    = we;
      exp_q.push_back({4'h0, exp});
      tag_q.push_back(tag);
      @(posedge clock); #1;
      wren = 1'b0;
      chk(tag_q.pop_front(), {4'h0, q}, exp_q.pop_front());
   endtask

   task automatic access2(input string tag, input logic we, input logic [5:0] a,
                          input logic [7:0] d, input logic [7:0] exp);
      c2_address = a;
      c2_data    = d;
      c2_wren    = we;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clock); #1;
      c2_wren = 1'b0;
      chk(tag_q.pop_front(), c2_q, exp_q.pop_front());
   endtask

   // Advance through the rest of a 16-word fill, checking ready rises on the 16th edge only.
   task automatic run_fill(input int done);
      for (int i = done + 1; i <= 16; i++) begin
         @(posedge clock); #1;
         if (i == 8)  chk("fill_q_zero", {4'h0, q}, 8'h00);
         if (i == 15) chk("fill_ready_lo", {7'h0, ready}, 8'h00);
         if (i == 16) chk("fill_ready_hi", {7'h0, ready}, 8'h01);
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_fail = 0;
      reset_n = 1'b0; rst2_n = 1'b0;
      address = '0; data = '0; wren = 1'b0; clr = 1'b0;
      c2_address = '0; c2_data = '0; c2_wren = 1'b0; c2_clr = 1'b0;

      // reset state and initial fill
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", {7'h0, ready}, 8'h00);
      chk("rst_q", {4'h0, q}, 8'h00);
      chk("rst_drop", {7'h0, wr_drop}, 8'h00);
      reset_n = 1'b1;
      run_fill(0);
      access("rd0", 1'b0, 4'd0, 4'h0, 4'hF);
      access("rd5", 1'b0, 4'd5, 4'h0, 4'hA);
      access("rd15", 1'b0, 4'd15, 4'h0, 4'h0);

      // write-first then read back
      access("wr3", 1'b1, 4'd3, 4'h7, 4'h7);
      access("rd3", 1'b0, 4'd3, 4'h0, 4'h7);

      // write attempt during fill is dropped
      pulse_reset();
      repeat (3) begin @(posedge clock); #1; end
      wren = 1'b1; address = 4'd2; data = 4'h9;
      @(posedge clock); #1;
      wren = 1'b0;
      chk("init_drop_hi", {7'h0, wr_drop}, 8'h01);
      @(posedge clock); #1;
      chk("init_drop_lo", {7'h0, wr_drop}, 8'h00);
      run_fill(5);
      access("rd2", 1'b0, 4'd2, 4'h0, 4'hD);

      // clr from READY with a colliding write refills the array
      access("wr1", 1'b1, 4'd1, 4'h0, 4'h0);
      clr = 1'b1; wren = 1'b1; address = 4'd1; data = 4'h5;
      @(posedge clock); #1;
      clr = 1'b0; wren = 1'b0;
      chk("clr_ready", {7'h0, ready}, 8'h00);
      chk("clr_q", {4'h0, q}, 8'h00);
      chk("clr_drop", {7'h0, wr_drop}, 8'h01);
      run_fill(0);
      access("rd1", 1'b0, 4'd1, 4'h0, 4'hE);

      // clr held mid-fill restarts the counter
      pulse_reset();
      repeat (10) begin @(posedge clock); #1; end
      clr = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         chk("clr_hold_ready", {7'h0, ready}, 8'h00);
      end
      clr = 1'b0;
      run_fill(0);
      access("rd9", 1'b0, 4'd9, 4'h0, 4'h6);

      // asynchronous reset mid-fill
      pulse_reset();
      repeat (4) begin @(posedge clock); #1; end
      wren = 1'b1;
      @(posedge clock); #1;
      wren = 1'b0;
      chk("pre_rst_drop", {7'h0, wr_drop}, 8'h01);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_fill_drop", {7'h0, wr_drop}, 8'h00);
      chk("arst_fill_ready", {7'h0, ready}, 8'h00);
      @(posedge clock); #1;
      reset_n = 1'b1;
      run_fill(0);

      // asynchronous reset right after a READY write
      access("wr4", 1'b1, 4'd4, 4'h3, 4'h3);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_rdy_q", {4'h0, q}, 8'h00);
      chk("arst_rdy_ready", {7'h0, ready}, 8'h00);
      @(posedge clock); #1;
      reset_n = 1'b1;
      run_fill(0);
      access("rd4", 1'b0, 4'd4, 4'h0, 4'hB);

      // wide configuration: 64-word fill
      rst2_n = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clock); #1;
         if (i == 63) chk("w_ready_lo", {7'h0, c2_ready}, 8'h00);
         if (i == 64) chk("w_ready_hi", {7'h0, c2_ready}, 8'h01);
      end
      access2("w_rd63", 1'b0, 6'd63, 8'h00, 8'hC0);
      access2("w_rd0", 1'b0, 6'd0, 8'h00, 8'hFF);
      access2("w_wr10", 1'b1, 6'd10, 8'h5A, 8'h5A);
      access2("w_rd10", 1'b0, 6'd10, 8'h00, 8'h5A);
      access2("w_rd11", 1'b0, 6'd11, 8'h00, 8'hF4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
